// File: rtl/alu_exec_unit.sv
// Decoding ALU execution unit: aluop/funct decode, single-cycle ops, iterative 1-bit shifter.
// Define ALU_EXEC_MUL_EN to add an iterative shift-add multiplier (MUL, latency XLEN).
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alucontrol
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] CtlAdd   = 4'b0000;
  localparam logic [3:0] CtlSub   = 4'b0001;
  localparam logic [3:0] CtlAnd   = 4'b0010;
  localparam logic [3:0] CtlOr    = 4'b0011;
  localparam logic [3:0] CtlXor   = 4'b0100;
  localparam logic [3:0] CtlSlt   = 4'b0101;
  localparam logic [3:0] CtlSltu  = 4'b0110;
  localparam logic [3:0] CtlSll   = 4'b0111;
  localparam logic [3:0] CtlSrl   = 4'b1000;
  localparam logic [3:0] CtlSra   = 4'b1001;
  localparam logic [3:0] CtlPassb = 4'b1010;
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] CtlMul   = 4'b1011;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StShift,
`ifdef ALU_EXEC_MUL_EN
    StMul,
`endif
    StHold
  } state_e;

  state_e          state;
  logic [SHW-1:0]  count;
  logic [3:0]      ctl;
  logic [XLEN-1:0] quick;
  logic [XLEN-1:0] first_shift;
  logic [XLEN-1:0] next_shift;
  logic [SHW-1:0]  shamt;
  logic            is_shift;

  function automatic logic [XLEN-1:0] shift1(input logic [3:0] c, input logic [XLEN-1:0] v);
    case (c)
      CtlSll:  return {v[XLEN-2:0], 1'b0};
      CtlSra:  return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  always_comb begin
    ctl = CtlAdd;
    case (aluop)
      2'b00: ctl = CtlAdd;
      2'b01: ctl = CtlSub;
      2'b11: ctl = CtlPassb;
      default: begin
        unique case (funct3)
          3'b000: ctl = (op[5] && funct7[5]) ? CtlSub : CtlAdd;
          3'b001: ctl = CtlSll;
          3'b010: ctl = CtlSlt;
          3'b011: ctl = CtlSltu;
          3'b100: ctl = CtlXor;
          3'b101: ctl = funct7[5] ? CtlSra : CtlSrl;
          3'b110: ctl = CtlOr;
          3'b111: ctl = CtlAnd;
        endcase
`ifdef ALU_EXEC_MUL_EN
        if (op[5] && funct7 == 7'b0000001 && funct3 == 3'b000) ctl = CtlMul;
`endif
      end
    endcase
  end

  always_comb begin
    quick = '0;
    case (ctl)
      CtlAdd:   quick = a + b;
      CtlSub:   quick = a - b;
      CtlAnd:   quick = a & b;
      CtlOr:    quick = a | b;
      CtlXor:   quick = a ^ b;
      CtlSlt:   quick = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      CtlSltu:  quick = {{(XLEN-1){1'b0}}, a < b};
      CtlPassb: quick = b;
      default:  quick = a;  // shift by zero
    endcase
  end

  assign shamt       = b[SHW-1:0];
  assign is_shift    = (ctl == CtlSll) || (ctl == CtlSrl) || (ctl == CtlSra);
  assign first_shift = shift1(ctl, a);
  assign next_shift  = shift1(alucontrol, result);
  assign in_ready    = (state == StIdle);

  logic unused_bits;
  assign unused_bits = ^{op[6], op[4:0], funct7[6], funct7[4:0]};

`ifdef ALU_EXEC_MUL_EN
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] mul_sum;
  assign mul_sum = result + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      result     <= '0;
      zero       <= 1'b0;
      out_valid  <= 1'b0;
      alucontrol <= CtlAdd;
      count      <= '0;
`ifdef ALU_EXEC_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            alucontrol <= ctl;
            if (is_shift && shamt != '0) begin
              // First bit shifts on the accept edge, so latency equals shamt.
              result <= first_shift;
              count  <= shamt - SHW'(1);
              if (shamt == SHW'(1)) begin
                state     <= StHold;
                out_valid <= 1'b1;
                zero      <= (first_shift == '0);
              end else begin
                state <= StShift;
                zero  <= 1'b0;
              end
            end
`ifdef ALU_EXEC_MUL_EN
            else if (ctl == CtlMul) begin
              result <= b[0] ? a : '0;
              mcand  <= a << 1;
              mplier <= b >> 1;
              count  <= {SHW{1'b1}};
              zero   <= 1'b0;
              state  <= StMul;
            end
`endif
            else begin
              result    <= quick;
              zero      <= (quick == '0);
              out_valid <= 1'b1;
              state     <= StHold;
            end
          end
        end
        StShift: begin
          result <= next_shift;
          count  <= count - SHW'(1);
          if (count == SHW'(1)) begin
            state     <= StHold;
            out_valid <= 1'b1;
            zero      <= (next_shift == '0);
          end
        end
`ifdef ALU_EXEC_MUL_EN
        StMul: begin
          result <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - SHW'(1);
          if (count == SHW'(1)) begin
            state     <= StHold;
            out_valid <= 1'b1;
            zero      <= (mul_sum == '0);
          end
        end
`endif
        StHold: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a spec-level model checked every cycle plus literal vectors.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  aluop = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [6:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alucontrol;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7     (funct7),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .alucontrol (alucontrol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: decode table, plain arithmetic, and latency rule.
  function automatic logic [3:0] m_decode(input logic [1:0] ao, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [6:0] o);
    if (ao == 2'b00) return 4'd0;
    if (ao == 2'b01) return 4'd1;
    if (ao == 2'b11) return 4'd10;
`ifdef ALU_EXEC_MUL_EN
    if (o[5] && f7 == 7'd1 && f3 == 3'd0) return 4'd11;
`endif
    case (f3)
      3'd0:    return (o[5] && f7[5]) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return f7[5] ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [31:0] m_result(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    int n;
    sx = x;
    sy = y;
    n = int'(y[4:0]);
    case (c)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return (sx < sy) ? 32'd1 : 32'd0;
      4'd6:    return (x < y) ? 32'd1 : 32'd0;
      4'd7:    return x << n;
      4'd8:    return x >> n;
      4'd9:    return sx >>> n;
      4'd10:   return y;
      default: return x * y;
    endcase
  endfunction

  function automatic int m_latency(input logic [3:0] c, input logic [31:0] y);
    int n;
    n = int'(y[4:0]);
    if (c == 4'd7 || c == 4'd8 || c == 4'd9) return (n == 0) ? 1 : n;
    if (c == 4'd11) return 32;
    return 1;
  endfunction

  // m_st: 0 idle, 1 busy, 2 result held
  int          m_st = 0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_ctrl = '0;
  logic        m_clean = 1'b1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st    <= 0;
      m_left  <= 0;
      m_res   <= '0;
      m_ctrl  <= '0;
      m_clean <= 1'b1;
    end else if (m_st == 2) begin
      if (out_ready) m_st <= 0;
    end else if (m_st == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_st <= 2;
    end else if (in_valid) begin
      m_ctrl  <= m_decode(aluop, funct3, funct7, op);
      m_res   <= m_result(m_decode(aluop, funct3, funct7, op), a, b);
      m_left  <= m_latency(m_decode(aluop, funct3, funct7, op), b) - 1;
      m_st    <= (m_latency(m_decode(aluop, funct3, funct7, op), b) == 1) ? 2 : 1;
      m_clean <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", 32'(in_ready), 32'(m_st == 0));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_st == 2));
    if (m_st == 2 || m_clean) begin
      chk("cyc_result", result, m_res);
      chk("cyc_zero", 32'(zero), 32'(!m_clean && m_res == 32'd0));
      chk("cyc_alucontrol", 32'(alucontrol), 32'(m_ctrl));
    end
  end

  task automatic run(input string nm, input logic [1:0] ao, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [6:0] o, input logic [31:0] aa,
                     input logic [31:0] bb, input logic [31:0] er, input int el,
                     input logic [3:0] ec, input int stall);
    int cyc;
    @(posedge clk);
    #1;
    aluop = ao; funct3 = f3; funct7 = f7; op = o; a = aa; b = bb;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      if (cyc == 1) begin
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        funct3 = 3'($urandom);
      end
      @(negedge clk);
    end while (!out_valid && cyc < 200);
    chk({nm, "_latency"}, 32'(cyc), 32'(el));
    chk({nm, "_result"}, result, er);
    chk({nm, "_ctrl"}, 32'(alucontrol), 32'(ec));
    chk({nm, "_zero"}, 32'(zero), 32'(er == 32'd0));
    if (stall > 0) begin
      in_valid = 1'b1;
      aluop = 2'b11;
      repeat (stall) begin
        @(negedge clk);
        chk({nm, "_hold_result"}, result, er);
        chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  localparam logic [6:0] OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run("sub_r", 2'b10, 3'd0, 7'h20, OpR, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 4'd1, 0);
    run("addi_f7", 2'b10, 3'd0, 7'h20, OpI, 32'd5, 32'd7, 32'd12, 1, 4'd0, 0);
    run("srai_bp", 2'b10, 3'd5, 7'h20, OpI, 32'h80000000, 32'd8, 32'hFF800000, 8, 4'd9, 5);
    run("sll_0", 2'b10, 3'd1, 7'h00, OpR, 32'h1234, 32'd0, 32'h1234, 1, 4'd7, 0);
    run("sll_25", 2'b10, 3'd1, 7'h00, OpI, 32'd1, 32'h25, 32'h20, 5, 4'd7, 0);
    run("sra_1", 2'b10, 3'd5, 7'h20, OpR, 32'h80000001, 32'd1, 32'hC0000000, 1, 4'd9, 0);
    run("srl_31", 2'b10, 3'd5, 7'h00, OpR, 32'h80000000, 32'd31, 32'd1, 31, 4'd8, 0);
    run("slt", 2'b10, 3'd2, 7'h00, OpR, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 4'd5, 0);
    run("sltu", 2'b10, 3'd3, 7'h00, OpR, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 4'd6, 0);
    run("passb", 2'b11, 3'd0, 7'h00, 7'b0110111, 32'h5, 32'h12345000, 32'h12345000, 1, 4'd10, 0);
    run("xor", 2'b10, 3'd4, 7'h00, OpI, 32'hF0F0, 32'hFF00, 32'h0FF0, 1, 4'd4, 0);
    run("or", 2'b10, 3'd6, 7'h00, OpI, 32'hF0F0, 32'hFF00, 32'hFFF0, 1, 4'd3, 2);
    run("and", 2'b10, 3'd7, 7'h00, OpR, 32'hF0F0, 32'hFF00, 32'hF000, 1, 4'd2, 0);
    run("add_wrap", 2'b00, 3'd5, 7'h20, OpR, 32'hFFFFFFFF, 32'd2, 32'd1, 1, 4'd0, 0);
    run("br_eq", 2'b01, 3'd0, 7'h00, 7'b1100011, 32'h55, 32'h55, 32'd0, 1, 4'd1, 0);

    // Reset during the third cycle of a 20-step SRL.
    @(posedge clk);
    #1;
    aluop = 2'b10; funct3 = 3'd5; funct7 = 7'h00; op = OpR;
    a = 32'hF0000000; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ctrl", 32'(alucontrol), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run("add_after_rst", 2'b10, 3'd0, 7'h00, OpR, 32'd1, 32'd1, 32'd2, 1, 4'd0, 0);

`ifdef ALU_EXEC_MUL_EN
    run("mul", 2'b10, 3'd0, 7'h01, OpR, 32'hFFFF, 32'h10001, 32'hFFFFFFFF, 32, 4'd11, 0);
    run("mul_neg", 2'b10, 3'd0, 7'h01, OpR, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32, 4'd11, 0);
`else
    run("mul_off", 2'b10, 3'd0, 7'h01, OpR, 32'hFFFF, 32'h10001, 32'h20000, 1, 4'd0, 0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
